// File: rtl/left_shift_seq_if.sv
// Operand/result handshake bundle for the sequential left shifter.
// The upstream/downstream side uses master, and the shifter uses slave.
interface left_shift_seq_if #(
  parameter int width = 8
) ();
  localparam int SW = $clog2(width);

  logic             i_valid;
  logic             i_ready;
  logic [width-1:0] i_bits;
  logic [SW-1:0]    shift;
  logic             o_valid;
  logic             o_ready;
  logic [width-1:0] o_bits;

  modport master (
    output i_valid, i_bits, shift, o_ready,
    input  i_ready, o_valid, o_bits
  );

  modport slave (
    input  i_valid, i_bits, shift, o_ready,
    output i_ready, o_valid, o_bits
  );
endinterface

// File: rtl/left_shift_seq.sv
// Sequential left shifter. It applies one log-shifter stage per clock and
// holds one operation in flight, with a valid/ready handshake on both sides.
module left_shift_seq #(
  parameter int width = 8
) (
  input  logic           clk,
  input  logic           rst,
  left_shift_seq_if.slave bus
);
  localparam int SW = $clog2(width);
  localparam logic [SW-1:0] LAST_STAGE = SW'(SW - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [width-1:0] data;
  logic [SW-1:0]    amt;
  logic [SW-1:0]    stage;
  logic [width-1:0] o_bits_q;
  logic             i_ready_q;
  logic             o_valid_q;

  logic             stage_en;
  logic [width-1:0] stage_data;

  // The shift for each stage is 2**stage. No single stage can move the data
  // by width or more, so a shift that is width or larger clears all the bits.
  always_comb begin
    stage_en   = |(amt & (SW'(1) << stage));
    stage_data = data;
    if (stage_en) stage_data = data << (32'd1 << stage);
  end

  // NOTE: all state here, including the data/amt datapath registers, is reset
  // so that an aborted operation leaves no trace. Every assignment uses <=.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      data      <= '0;
      amt       <= '0;
      stage     <= '0;
      o_bits_q  <= '0;
      i_ready_q <= 1'b1;
      o_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.i_valid) begin
            data      <= bus.i_bits;
            amt       <= bus.shift;
            stage     <= '0;
            i_ready_q <= 1'b0;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          data <= stage_data;
          if (stage == LAST_STAGE) begin
            // o_bits keeps its own copy, so it holds after the handshake.
            o_bits_q  <= stage_data;
            o_valid_q <= 1'b1;
            state     <= DONE;
          end else begin
            stage <= stage + 1'b1;
          end
        end
        DONE: begin
          if (bus.o_ready) begin
            o_valid_q <= 1'b0;
            i_ready_q <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          i_ready_q <= 1'b1;
          o_valid_q <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  assign bus.i_ready = i_ready_q;
  assign bus.o_valid = o_valid_q;
  assign bus.o_bits  = o_bits_q;
endmodule

// File: tb/tb_left_shift_seq.sv
// Directed and randomized checks of left_shift_seq at width 8 and width 6.
// The expected results come from hand-computed constants and a shift-and-mask model.
module tb_left_shift_seq;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  left_shift_seq_if #(.width(8)) if8 ();
  left_shift_seq_if #(.width(6)) if6 ();

  left_shift_seq #(.width(8)) dut8 (.clk(clk), .rst(rst), .bus(if8));
  left_shift_seq #(.width(6)) dut6 (.clk(clk), .rst(rst), .bus(if6));

  // The common stimulus is steered to one instance. sel=0 selects width 8, sel=1 selects width 6.
  logic       sel = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b1;
  logic [7:0] in_bits = '0;
  logic [2:0] in_shift = '0;

  assign if8.i_valid = in_valid & ~sel;
  assign if8.i_bits  = in_bits;
  assign if8.shift   = in_shift;
  assign if8.o_ready = out_ready;
  assign if6.i_valid = in_valid & sel;
  assign if6.i_bits  = in_bits[5:0];
  assign if6.shift   = in_shift;
  assign if6.o_ready = out_ready;

  logic       obs_ready, obs_valid;
  logic [7:0] obs_bits;
  assign obs_ready = sel ? if6.i_ready : if8.i_ready;
  assign obs_valid = sel ? if6.o_valid : if8.o_valid;
  assign obs_bits  = sel ? {2'b00, if6.o_bits} : if8.o_bits;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Run one operation. The result is expected after exactly 3 edges past acceptance.
  task automatic op(input string tag, input logic [7:0] bits, input logic [2:0] sh,
                    input logic [7:0] exp);
    int n;
    n = 0;
    while (!obs_ready && n < 20) begin @(posedge clk); #1; n++; end
    check({tag, "_ready_in"}, 32'(obs_ready), 32'd1);
    in_bits = bits; in_shift = sh; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({tag, "_busy"}, 32'(obs_ready), 32'd0);
    n = 0;
    while (!obs_valid && n < 20) begin @(posedge clk); #1; n++; end
    check({tag, "_latency"}, 32'(n), 32'd3);
    check({tag, "_bits"}, 32'(obs_bits), 32'(exp));
    check({tag, "_done_not_ready"}, 32'(obs_ready), 32'd0);
    if (out_ready) begin
      @(posedge clk); #1;
      check({tag, "_valid_drop"}, 32'(obs_valid), 32'd0);
      check({tag, "_ready_back"}, 32'(obs_ready), 32'd1);
    end
  endtask

  initial begin
    logic [5:0] exp_q[$];
    logic [5:0] e6;
    int         n_acc, n_done, cyc;

    // Check the outputs while reset is held.
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(obs_valid), 32'd0);
    check("rst_bits", 32'(obs_bits), 32'd0);
    #2 rst = 1'b1;
    @(posedge clk); #1;
    check("rst_ready", 32'(obs_ready), 32'd1);

    // Basic shifts, where bits are lost past the MSB, and a zero-shift case with no early exit.
    op("t1", 8'h81, 3'd1, 8'h02);
    op("t2", 8'hA5, 3'd0, 8'hA5);
    op("t3a", 8'hFF, 3'd7, 8'h80);
    op("t3b", 8'h0F, 3'd4, 8'hF0);

    // Backpressure. The result must hold, and new operands must be ignored.
    out_ready = 1'b0;
    op("t4", 8'h03, 3'd2, 8'h0C);
    for (int i = 0; i < 5; i++) begin
      in_bits = 8'hFF; in_shift = 3'd1; in_valid = (i % 2 == 0);
      @(posedge clk); #1;
      check("t4_hold_valid", 32'(obs_valid), 32'd1);
      check("t4_hold_bits", 32'(obs_bits), 32'h0C);
      check("t4_hold_ready", 32'(obs_ready), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("t4_release_valid", 32'(obs_valid), 32'd0);
    check("t4_release_ready", 32'(obs_ready), 32'd1);
    repeat (5) @(posedge clk);
    #1;
    check("t4_no_ghost", 32'(obs_valid), 32'd0);
    check("t4_bits_kept", 32'(obs_bits), 32'h0C);

    // Reset in the middle of an operation.
    in_bits = 8'h55; in_shift = 3'd2; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    check("t5_abort_valid", 32'(obs_valid), 32'd0);
    check("t5_abort_bits", 32'(obs_bits), 32'd0);
    @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #1;
    check("t5_ready_after", 32'(obs_ready), 32'd1);
    repeat (5) @(posedge clk);
    #1;
    check("t5_no_result", 32'(obs_valid), 32'd0);
    op("t5", 8'h01, 3'd3, 8'h08);

    // Width 6, where the width is not a power of two.
    sel = 1'b1;
    @(posedge clk); #1;
    op("t6a", 8'h2A, 3'd7, 8'h00);
    op("t6b", 8'h3F, 3'd5, 8'h20);
    op("t6c", 8'h07, 3'd6, 8'h00);

    // Random operands with random valid/ready, checked against a scoreboard.
    n_acc = 0; n_done = 0; cyc = 0;
    while (n_done < 1000 && cyc < 40000) begin
      in_valid  = ($urandom_range(0, 1) == 1) && (n_acc < 1000);
      out_ready = ($urandom_range(0, 1) == 1);
      in_bits   = 8'($urandom);
      in_shift  = 3'($urandom);
      if (in_valid && obs_ready) begin
        e6 = in_bits[5:0] << in_shift;
        exp_q.push_back(e6);
        n_acc++;
      end
      if (obs_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("rand_unexpected", 32'd1, 32'd0);
        end else begin
          e6 = exp_q.pop_front();
          check("rand_bits", 32'(obs_bits), 32'(e6));
        end
        n_done++;
      end
      check("rand_excl", 32'(obs_valid & obs_ready), 32'd0);
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("rand_count", 32'(n_done), 32'd1000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
